// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared key codes, FSM state encoding and defaults for the ATM front end
package atm_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  localparam int DEF_PIN_DIGITS   = 4;
  localparam int DEF_MAX_ATTEMPTS = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_CHECK   = 3'd2,
    ST_DONE    = 3'd3,
    ST_LOCKED  = 3'd4
  } pin_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_idle_timer.sv
// rtl/atm_idle_timer.sv - inactivity counter with clear, enable and one-cycle expire
module atm_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  // Expire fires on the TIMEOUT_CYCLES-th enabled cycle after a clear.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/pin_verifier.sv
// rtl/pin_verifier.sv - keypad PIN assembly, compare against stored PIN, attempt counting and lockout
module pin_verifier
  import atm_pkg::*;
#(
  parameter int PIN_DIGITS     = DEF_PIN_DIGITS,
  parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    card_inserted,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  input  logic [4*PIN_DIGITS-1:0] stored_pin,
  output logic                    pin_valid,
  output logic                    pin_fail,
  output logic                    account_locked,
  output logic [1:0]              attempts_left,
  output logic [2:0]              digits_entered,
  output logic                    timeout_abort
);

  localparam int BW = 4 * PIN_DIGITS;
  localparam logic [2:0] PIN_CNT = 3'(PIN_DIGITS);
  localparam logic [1:0] ATT_MAX = 2'(MAX_ATTEMPTS);

  pin_state_t    state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [1:0]    att_q, att_d;
  logic          valid_q, valid_d;
  logic          fail_q, fail_d;
  logic          lock_q, lock_d;
  logic          tmo_q, tmo_d;

  logic key_acc;
  logic tmr_clear, tmr_en, tmr_expire;

  // Codes C-F are not accepted keys: they neither act nor restart the idle timer.
  assign key_acc = key_valid && (key_code <= KEY_ENTER);

  atm_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear_i (tmr_clear),
    .en_i    (tmr_en),
    .expire_o(tmr_expire)
  );

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    att_d     = att_q;
    fail_d    = 1'b0;
    tmo_d     = 1'b0;
    tmr_clear = 1'b1;
    tmr_en    = 1'b0;

    if (!card_inserted) begin
      // Card removal wins over any key, ENTER or timeout in the same cycle.
      state_d = ST_IDLE;
      buf_d   = '0;
      cnt_d   = '0;
      att_d   = ATT_MAX;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_COLLECT;
          buf_d   = '0;
          cnt_d   = '0;
          att_d   = ATT_MAX;
        end
        ST_COLLECT: begin
          tmr_en    = 1'b1;
          tmr_clear = key_acc;
          if (key_acc) begin
            if (is_digit(key_code)) begin
              if (cnt_q < PIN_CNT) begin
                buf_d = {buf_q[BW-5:0], key_code};
                cnt_d = cnt_q + 3'd1;
              end
            end else if (key_code == KEY_CLEAR) begin
              buf_d = '0;
              cnt_d = '0;
            end else begin
              state_d = ST_CHECK;
            end
          end else if (tmr_expire) begin
            tmo_d   = 1'b1;
            state_d = ST_IDLE;
            buf_d   = '0;
            cnt_d   = '0;
            att_d   = ATT_MAX;
          end
        end
        ST_CHECK: begin
          // A short entry can never match, even if the shifted buffer happens to equal stored_pin.
          if ((cnt_q == PIN_CNT) && (buf_q == stored_pin)) begin
            state_d = ST_DONE;
          end else if (att_q > 2'd1) begin
            att_d   = att_q - 2'd1;
            fail_d  = 1'b1;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = ST_COLLECT;
          end else begin
            att_d   = 2'd0;
            state_d = ST_LOCKED;
          end
        end
        ST_DONE, ST_LOCKED: begin
          state_d = state_q;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    valid_d = (state_d == ST_DONE);
    lock_d  = (state_d == ST_LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      att_q   <= ATT_MAX;
      valid_q <= 1'b0;
      fail_q  <= 1'b0;
      lock_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      att_q   <= att_d;
      valid_q <= valid_d;
      fail_q  <= fail_d;
      lock_q  <= lock_d;
      tmo_q   <= tmo_d;
    end
  end

  assign pin_valid      = valid_q;
  assign pin_fail       = fail_q;
  assign account_locked = lock_q;
  assign attempts_left  = att_q;
  assign digits_entered = cnt_q;
  assign timeout_abort  = tmo_q;

endmodule

// File: tb/tb_pin_verifier.sv
// tb/tb_pin_verifier.sv - scenario and randomized bench for pin_verifier against a session-level model
module tb_pin_verifier;

  localparam int TMO  = 20;
  localparam int MAXA = 3;
  localparam int ND   = 4;

  localparam int P_IDLE = 0, P_COLLECT = 1, P_CHECK = 2, P_DONE = 3, P_LOCKED = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        card_inserted;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] stored_pin;
  logic        pin_valid, pin_fail, account_locked, timeout_abort;
  logic [1:0]  attempts_left;
  logic [2:0]  digits_entered;

  int vectors = 0;
  int miscompares = 0;

  int ph;
  int q[$];
  int att;
  int idle;
  bit e_fail, e_tmo;

  pin_verifier #(
    .PIN_DIGITS    (ND),
    .MAX_ATTEMPTS  (MAXA),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .card_inserted (card_inserted),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .stored_pin    (stored_pin),
    .pin_valid     (pin_valid),
    .pin_fail      (pin_fail),
    .account_locked(account_locked),
    .attempts_left (attempts_left),
    .digits_entered(digits_entered),
    .timeout_abort (timeout_abort)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {pin_valid, pin_fail, account_locked, attempts_left, digits_entered, timeout_abort};
  endfunction

  function automatic logic [8:0] expv();
    return {ph == P_DONE, e_fail, ph == P_LOCKED, 2'(att), 3'(q.size()), e_tmo};
  endfunction

  task automatic model_reset();
    ph = P_IDLE; q.delete(); att = MAXA; idle = 0; e_fail = 0; e_tmo = 0;
  endtask

  // Session-level reference: a digit queue, an attempt budget and an idle count.
  task automatic model_step(input bit card, input bit kv, input int kc);
    int pin;
    e_fail = 0; e_tmo = 0;
    if (!card) begin
      ph = P_IDLE; q.delete(); att = MAXA;
    end else if (ph == P_IDLE) begin
      ph = P_COLLECT; q.delete(); att = MAXA; idle = 0;
    end else if (ph == P_COLLECT) begin
      if (kv && kc <= 11) begin
        idle = 0;
        if (kc <= 9) begin
          if (q.size() < ND) q.push_back(kc);
        end else if (kc == 10) q.delete();
        else ph = P_CHECK;
      end else begin
        idle++;
        if (idle == TMO) begin
          e_tmo = 1; ph = P_IDLE; q.delete(); att = MAXA;
        end
      end
    end else if (ph == P_CHECK) begin
      pin = 0;
      foreach (q[i]) pin = pin * 16 + q[i];
      if (q.size() == ND && pin == int'(stored_pin)) ph = P_DONE;
      else if (att > 1) begin
        att--; e_fail = 1; q.delete(); ph = P_COLLECT; idle = 0;
      end else begin
        att = 0; ph = P_LOCKED;
      end
    end
  endtask

  task automatic drive(input bit card, input bit kv, input int kc);
    card_inserted = card; key_valid = kv; key_code = 4'(kc);
    model_step(card, kv, kc);
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; card_inserted = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic new_session();
    drive(0, 0, 0);
    drive(1, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (obs() !== 9'b0_0_0_11_000_0) begin
      miscompares++; $display("FAIL reset_values: got %b want %b", obs(), 9'b0_0_0_11_000_0);
    end
  endtask

  task automatic test_match();
    int seq[] = '{1, 2, 3, 4, 11};
    stored_pin = 16'h1234;
    new_session();
    foreach (seq[i]) begin
      drive(1, 1, seq[i]);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL match_key%0d: got %b want %b", i, obs(), expv());
      end
    end
    vectors++;
    if (pin_valid !== 1'b0) begin
      miscompares++; $display("FAIL match_check_cycle: pin_valid=%b want 0", pin_valid);
    end
    drive(1, 0, 0);
    vectors++;
    if (pin_valid !== 1'b1 || attempts_left !== 2'd3) begin
      miscompares++; $display("FAIL match_done: pin_valid=%b attempts=%0d want 1,3", pin_valid, attempts_left);
    end
  endtask

  task automatic test_lockout();
    int seq[] = '{1, 1, 1, 1, 11, 0};
    int fails = 0;
    stored_pin = 16'h1234;
    new_session();
    for (int a = 0; a < 3; a++) begin
      foreach (seq[i]) begin
        drive(1, i < 5, seq[i]);
        if (pin_fail) fails++;
        vectors++;
        if (obs() !== expv()) begin
          miscompares++; $display("FAIL lock_try%0d_step%0d: got %b want %b", a, i, obs(), expv());
        end
      end
      vectors++;
      if (a < 2 && (attempts_left !== 2'(2 - a) || account_locked !== 1'b0)) begin
        miscompares++; $display("FAIL lock_attempts%0d: attempts=%0d locked=%b want %0d,0", a, attempts_left, account_locked, 2 - a);
      end else if (a == 2 && (account_locked !== 1'b1 || pin_fail !== 1'b0)) begin
        miscompares++; $display("FAIL lock_final: locked=%b pin_fail=%b want 1,0", account_locked, pin_fail);
      end
    end
    vectors++;
    if (fails != 2) begin
      miscompares++; $display("FAIL lock_fail_count: got %0d want 2", fails);
    end
    drive(0, 0, 0);
    vectors++;
    if (account_locked !== 1'b0) begin
      miscompares++; $display("FAIL lock_release: locked=%b want 0", account_locked);
    end
  endtask

  task automatic test_clear_overflow();
    int seq[] = '{9, 9, 10, 1, 2, 3, 4, 5, 11, 0};
    stored_pin = 16'h1234;
    new_session();
    foreach (seq[i]) begin
      drive(1, i < 9, seq[i]);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL clear_step%0d: got %b want %b", i, obs(), expv());
      end
      if (i == 7) begin
        vectors++;
        if (digits_entered !== 3'd4) begin
          miscompares++; $display("FAIL clear_saturate: digits=%0d want 4", digits_entered);
        end
      end
    end
    vectors++;
    if (pin_valid !== 1'b1 || attempts_left !== 2'd3) begin
      miscompares++; $display("FAIL clear_done: pin_valid=%b attempts=%0d want 1,3", pin_valid, attempts_left);
    end
  endtask

  task automatic test_short();
    stored_pin = 16'h0012;
    new_session();
    drive(1, 1, 1);
    drive(1, 1, 2);
    drive(1, 1, 11);
    drive(1, 0, 0);
    vectors++;
    if (pin_fail !== 1'b1 || attempts_left !== 2'd2 || digits_entered !== 3'd0 || pin_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL short_entry: fail=%b att=%0d dig=%0d valid=%b want 1,2,0,0", pin_fail, attempts_left, digits_entered, pin_valid);
    end
  endtask

  task automatic test_timeout();
    stored_pin = 16'h1234;
    new_session();
    drive(1, 1, 1);
    drive(1, 1, 2);
    for (int i = 1; i <= TMO; i++) begin
      drive(1, $urandom_range(0, 1), $urandom_range(12, 15));
      vectors++;
      if (timeout_abort !== (i == TMO) || obs() !== expv()) begin
        miscompares++; $display("FAIL timeout_wait%0d: got %b want %b", i, obs(), expv());
      end
    end
    vectors++;
    if (digits_entered !== 3'd0) begin
      miscompares++; $display("FAIL timeout_clear: digits=%0d want 0", digits_entered);
    end
    drive(1, 0, 0);
    vectors++;
    if (timeout_abort !== 1'b0) begin
      miscompares++; $display("FAIL timeout_pulse_width: timeout_abort=%b want 0", timeout_abort);
    end
  endtask

  task automatic test_card_drop();
    stored_pin = 16'h1234;
    new_session();
    for (int d = 1; d <= 4; d++) drive(1, 1, d);
    drive(0, 1, 11);
    vectors++;
    if (obs() !== 9'b0_0_0_11_000_0) begin
      miscompares++; $display("FAIL drop_enter: got %b want %b", obs(), 9'b0_0_0_11_000_0);
    end
    drive(0, 0, 0);
    vectors++;
    if (pin_valid !== 1'b0 || pin_fail !== 1'b0) begin
      miscompares++; $display("FAIL drop_after: valid=%b fail=%b want 0,0", pin_valid, pin_fail);
    end
    new_session();
    for (int a = 0; a < 3; a++) begin
      drive(1, 1, 9); drive(1, 1, 11); drive(1, 0, 0);
    end
    vectors++;
    if (account_locked !== 1'b1) begin
      miscompares++; $display("FAIL drop_lock: locked=%b want 1", account_locked);
    end
    card_inserted = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    vectors++;
    if (obs() !== 9'b0_0_0_11_000_0) begin
      miscompares++; $display("FAIL reset_in_lock: got %b want %b", obs(), 9'b0_0_0_11_000_0);
    end
  endtask

  task automatic test_random();
    int kc;
    bit card = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset();
        card = 0;
      end
      if ($urandom_range(0, 149) == 0) card = 0;
      else if (!card && $urandom_range(0, 3) == 0) begin
        card = 1;
        stored_pin = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end
      if ($urandom_range(0, 1) == 0) kc = int'(stored_pin[4*(3 - (q.size() > 3 ? 3 : q.size())) +: 4]);
      else if ($urandom_range(0, 3) == 0) kc = 11;
      else kc = $urandom_range(0, 15);
      drive(card, $urandom_range(0, 1), kc);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++; $display("FAIL random_cycle%0d: got %b want %b", n, obs(), expv());
      end
    end
  endtask

  initial begin
    reset = 1'b1; card_inserted = 1'b0; key_valid = 1'b0; key_code = 4'h0; stored_pin = 16'h0;
    model_reset();
    test_reset();
    test_match();
    drive(0, 0, 0);
    test_lockout();
    test_clear_overflow();
    test_short();
    test_timeout();
    test_card_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
